// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
// Provides the default reset PC, the queue entry layout and a helper for
// counter widths so fetch_unit and fetch_queue size their counters alike.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  // One prefetch queue slot: instruction word plus the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned ctr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of DEPTH {pc, data} entries.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data,
//   push_pc             write one entry at the tail
//   pop                 discard the head entry
//   flush               empty the queue (wins over push/pop)
//   count               number of stored entries (0..DEPTH)
//   head_data, head_pc  head entry, read straight from the storage registers
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic [31:0]              push_pc,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              head_data,
  output logic [31:0]              head_pc
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: push_pc, data: push_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr].data;
  assign head_pc   = mem[rd_ptr].pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// Issues sequential word-address reads, buffers in-order responses in a
// DEPTH-entry prefetch queue and presents {instr_data, instr_pc} with a
// valid/ready handshake. A redirect flushes queued and in-flight words and
// restarts fetch at redirect_pc.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req_valid/addr/ready         read request channel
//   imem_resp_valid/data              in-order read response channel
//   instr_valid/data/pc/ready         issue handshake (queue head)
//   redirect_valid/pc                 flush and restart fetch
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW      = ctr_width(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   ret_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          accept;
  logic          live_resp;
  logic          push;
  logic          pop;

  // Queued plus in-flight words never exceed DEPTH, so the queue cannot overflow.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (drop == '0) && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;

  assign accept    = imem_req_valid && imem_req_ready;
  assign live_resp = imem_resp_valid && (drop == '0);
  assign push      = live_resp && !redirect_valid;
  assign pop       = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid = (count != '0);

  // On redirect every word still owed by memory becomes a drop credit. Folding
  // drop into the sum also covers a redirect that arrives while still draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      ret_pc      <= redirect_pc;
      drop        <= drop + outstanding - CW'(imem_resp_valid);
      outstanding <= '0;
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd1;
      if (push)   ret_pc   <= ret_pc + 32'd1;
      if (imem_resp_valid && (drop != '0)) drop <= drop - 1'b1;
      case ({accept, live_resp})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (imem_resp_data),
    .push_pc   (ret_pc),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_data (instr_data),
    .head_pc   (instr_pc)
  );

endmodule
